// File: rtl/nasti_burst_master_if.sv
// nasti_channel: NASTI (AXI4) channel bundle shared by initiators and targets.
// Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH.
// Modports:
//   master - drives AW/W/AR payloads and valids, b_ready and r_ready.
//   slave  - the mirror image, used by behavioural targets and benches.
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
);

  // Write address channel
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;

  // Write data channel
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;

  // Write response channel
  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;

  // Read address channel
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;

  // Read data channel
  logic                    r_valid;
  logic                    r_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );

endinterface

// File: rtl/nasti_burst_master.sv
// nasti_burst_master: single-outstanding NASTI INCR burst initiator.
// A command (cmd_*) becomes one read or one write burst. Write beats flow
// combinationally from wd_* onto W, read beats flow from R onto rd_*, and a
// single done_valid pulse with done_resp reports the outcome.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cmd_valid/ready      command handshake; cmd_write, cmd_addr, cmd_len
//   wd_valid/ready       write-data stream; wd_data, wd_strb
//   rd_valid/ready       read-data stream; rd_data, rd_last
//   done_valid           one-cycle completion pulse with done_resp
//   busy                 high whenever a command is in flight
//   nasti                NASTI master modport
module nasti_burst_master #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1,
  parameter int ID_VALUE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic                    busy,
  nasti_channel.master            nasti
);

  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [1:0]              resp_q;
  logic [1:0]              r_resp_next;
  logic                    aw_valid_q, ar_valid_q;
  logic                    cmd_fire, aw_fire, ar_fire, w_fire, b_fire, r_fire;
  logic                    last_beat;
  logic [31:0]             page_span_end;
  logic                    unused_inputs;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_fire   = aw_valid_q && nasti.aw_ready;
  assign ar_fire   = ar_valid_q && nasti.ar_ready;
  assign w_fire    = (state_q == W) && wd_valid && nasti.w_ready;
  assign b_fire    = (state_q == B) && nasti.b_valid;
  assign r_fire    = (state_q == R) && nasti.r_valid && rd_ready;
  assign last_beat = (cnt_q == len_q);

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the stream/status outputs that depend on state.
  // cmd_ready also looks at rst so it reads 0 throughout reset.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = (state_q == IDLE) && !rst;
    busy       = (state_q != IDLE);
    done_valid = (state_q == DONE);
    wd_ready   = (state_q == W) && nasti.w_ready;
    rd_valid   = (state_q == R) && nasti.r_valid;
    rd_last    = (state_q == R) && last_beat;
    unique case (state_q)
      IDLE: if (cmd_fire) state_d = cmd_write ? AW : AR;
      AW:   if (aw_fire) state_d = W;
      W:    if (w_fire && last_beat) state_d = B;
      B:    if (b_fire) state_d = DONE;
      AR:   if (ar_fire) state_d = R;
      R:    if (r_fire && last_beat) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read status merge: keep the worst response seen, and flag a protocol
  // error when the slave's r_last disagrees with our own beat count.
  always_comb begin
    r_resp_next = (nasti.r_resp > resp_q) ? nasti.r_resp : resp_q;
    if ((nasti.r_last != last_beat) && (r_resp_next != 2'b11))
      r_resp_next = 2'b10;
  end

  // Command capture, address-valid flags, beat counter and status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      resp_q     <= '0;
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q     <= cmd_addr & ADDR_MASK;
        len_q      <= cmd_len;
        cnt_q      <= '0;
        resp_q     <= '0;
        aw_valid_q <= cmd_write;
        ar_valid_q <= !cmd_write;
      end
      if (aw_fire) aw_valid_q <= 1'b0;
      if (ar_fire) ar_valid_q <= 1'b0;
      if (w_fire || r_fire) cnt_q <= cnt_q + 8'd1;
      if (b_fire) resp_q <= nasti.b_resp;
      if (r_fire) resp_q <= r_resp_next;
    end
  end

  // Bursts are never split, so a command crossing a 4 KB page is a caller bug.
  assign page_span_end = 32'(12'(cmd_addr & ADDR_MASK))
                       + ((32'(cmd_len) + 32'd1) << SIZE);

  always @(posedge clk) begin
    if (!rst && cmd_fire) assert (page_span_end <= 32'h1000);
  end

  assign done_resp = resp_q;
  assign rd_data   = nasti.r_data;

  assign nasti.aw_valid  = aw_valid_q;
  assign nasti.aw_id     = ID_WIDTH'(ID_VALUE);
  assign nasti.aw_addr   = addr_q;
  assign nasti.aw_len    = len_q;
  assign nasti.aw_size   = 3'(SIZE);
  assign nasti.aw_burst  = 2'b01;
  assign nasti.aw_lock   = 1'b0;
  assign nasti.aw_cache  = '0;
  assign nasti.aw_prot   = '0;
  assign nasti.aw_qos    = '0;
  assign nasti.aw_region = '0;
  assign nasti.aw_user   = '0;

  assign nasti.w_valid = (state_q == W) && wd_valid;
  assign nasti.w_data  = wd_data;
  assign nasti.w_strb  = wd_strb;
  assign nasti.w_last  = (state_q == W) && last_beat;
  assign nasti.w_user  = '0;

  assign nasti.b_ready = (state_q == B);

  assign nasti.ar_valid  = ar_valid_q;
  assign nasti.ar_id     = ID_WIDTH'(ID_VALUE);
  assign nasti.ar_addr   = addr_q;
  assign nasti.ar_len    = len_q;
  assign nasti.ar_size   = 3'(SIZE);
  assign nasti.ar_burst  = 2'b01;
  assign nasti.ar_lock   = 1'b0;
  assign nasti.ar_cache  = '0;
  assign nasti.ar_prot   = '0;
  assign nasti.ar_qos    = '0;
  assign nasti.ar_region = '0;
  assign nasti.ar_user   = '0;

  assign nasti.r_ready = (state_q == R) && rd_ready;

  // Only one transaction is ever outstanding, so response IDs and user bits
  // carry no information for us.
  assign unused_inputs = ^{nasti.b_id, nasti.b_user, nasti.r_id, nasti.r_user};

endmodule
